shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Sequencing controller for the 8-bit shifter datapath (shifter8: 3-bit op, 2-bit shamt, registered d_out). Accepts one shift command per handshake with a total shift amount of 0–15. Loads the operand into the shifter, then issues as many ≤3-bit shift steps as needed, and returns the registered result with a one-cycle done pulse. Sits between the command source and one shifter8 instance; the integration level instantiates both side by side.

## Interface

Parameters: none; widths are fixed by the shifter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- cmd_op  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 reserved
- cmd_amt  in  4  total shift distance, 0–15
- cmd_data  in  8  operand
- busy  out  1  high from the LOAD cycle through the CAPT cycle
- done  out  1  one-cycle pulse; result valid while high and held afterwards
- result  out  8  final shifted value, registered
- sh_op  out  3  shifter op: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100
- sh_shamt  out  2  per-step shift amount to the shifter
- sh_d_in  out  8  operand to the shifter
- sh_d_out  in  8  registered shifter output

## Operation

- States: IDLE, LOAD, SHIFT, CAPT.
- IDLE
  - sh_op = NOP, shamt = 0.
  - If start = 1: latch op_q, rem_q = cmd_amt (forced to 0 when cmd_op = 11) and cmd_data, then go to LOAD.
- LOAD
  - sh_op = LOAD, sh_d_in = latched data.
  - Next state: SHIFT if rem_q ≠ 0, else CAPT.
- SHIFT
  - sh_op = latched op.
  - step = 3 if rem_q ≥ 3, else rem_q; sh_shamt = step; rem_q -= step.
  - Leave for CAPT when the issued step brings rem_q to 0.
  - Example: cmd_amt 7 issues steps 3, 3, 1.
- CAPT
  - sh_op = NOP (shifter holds its value).
  - At the closing edge: result <= sh_d_out, done <= 1; go to IDLE.
- Every step is issued even when cmd_amt ≥ 8, with no shortcut. Final value: LSL/LSR give 0, ASR gives sign fill.
- sh_d_in holds the latched data in every state; it is ignored outside LOAD.
- Reserved cmd_op = 11 behaves as load-only: result = cmd_data.

## Timing

- Let N = ceil(cmd_amt/3), range 0..5.
- Schedule, with start sampled at edge E0:
  - LOAD in cycle 1
  - SHIFT in cycles 2..N+1
  - CAPT in cycle N+2
  - done = 1 and busy = 0 in cycle N+3
- Latency from start to done is N+3 cycles. Minimum 3 (amt 0), maximum 8 (amt 13–15).
- start while busy is ignored and not queued.
- start in the done cycle is accepted: back-to-back throughput is N+3 cycles per command.
- Reset values: state IDLE, busy 0, done 0, result 00h, sh_op NOP, sh_shamt 0, sh_d_in 00h, rem_q 0.
- Reset mid-operation:
  - The next cycle is IDLE with NOP and no done pulse; result keeps 00h.
  - The shifter's own register is not cleared by this block. Its contents are don't-care until the next LOAD.
- The shifter's reset_n is tied to ~reset at integration.

## Structure

- Package shifter_pkg holds:
  - The SH_NOP/LOAD/LSL/LSR/ASR 3-bit constants.
  - The cmd_op 2-bit codes.
  - The state enum (IDLE/LOAD/SHIFT/CAPT).
  - MAX_STEP = 3.
- No sub-module: a single FSM with its datapath registers (op_q, rem_q, data_q, result, done).
- The shifter8 instance lives in the parent (shift_unit), not inside this block.

## Test plan

- Reset held 2 cycles, then released with start = 0 → busy 0, done 0, result 00h, sh_op 000 held indefinitely.
- LSL, amt 5, data 03h → sh_shamt sequence 3, 2. result 60h. done exactly 5 cycles after the start edge, high for one cycle.
- ASR, amt 7, data 80h → steps 3, 3, 1, result FFh, latency 6. Then immediate back-to-back LSR, amt 0, data A5h → result A5h, latency 3.
- LSR, amt 15, data FFh → 5 steps (3×5), result 00h, latency 8. start pulses with other data during busy are ignored; result is unaffected.
- cmd_op 11, amt 9, data 3Ch → LOAD only, no SHIFT cycles, result 3Ch, latency 3.
- reset asserted in the 2nd SHIFT cycle of LSL amt 9 → next cycle IDLE, busy 0, sh_op NOP, no done. A new LSL amt 1 on data 01h then yields result 02h.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the shift_sequencer controller and the shifter8
// datapath it drives:
//   - SH_* : 3-bit shifter op codes (sh_op)
//   - OP_* : 2-bit command op codes (cmd_op)
//   - state_t : controller states
//   - MAX_STEP : largest distance one shifter step can cover
//   - op_to_sh / step_of : helpers for op translation and step sizing
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_LSR  = 3'b011;
    localparam logic [2:0] SH_ASR  = 3'b100;

    localparam logic [1:0] OP_LSL  = 2'b00;
    localparam logic [1:0] OP_LSR  = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [3:0] MAX_STEP = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CAPT  = 2'd3
    } state_t;

    // Command op -> shifter op. The reserved code never reaches SHIFT
    // (its distance is forced to 0), so NOP is only a safe fallback.
    function automatic logic [2:0] op_to_sh(input logic [1:0] op);
        case (op)
            OP_LSL:  return SH_LSL;
            OP_LSR:  return SH_LSR;
            OP_ASR:  return SH_ASR;
            default: return SH_NOP;
        endcase
    endfunction

    // Distance of the next step: as much of the remainder as one step allows.
    function automatic logic [1:0] step_of(input logic [3:0] rem);
        return (rem >= MAX_STEP) ? MAX_STEP[1:0] : rem[1:0];
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Sequences one shift command (distance 0..15) onto an 8-bit shifter that can
// only move 0..3 bits per cycle: LOAD the operand, issue ceil(amt/3) steps,
// then capture the shifter's registered output and pulse done.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             command strobe, only honoured in IDLE
//   cmd_op[1:0]       00 LSL, 01 LSR, 10 ASR, 11 reserved (load only)
//   cmd_amt[3:0]      total shift distance
//   cmd_data[7:0]     operand
//   busy              high from LOAD through CAPT
//   done              one-cycle pulse, result valid from then on
//   result[7:0]       captured result
//   sh_op[2:0]        op to the shifter
//   sh_shamt[1:0]     per-step distance to the shifter
//   sh_d_in[7:0]      operand to the shifter (latched command data)
//   sh_d_out[7:0]     registered shifter output
// -----------------------------------------------------------------------------
module shift_sequencer
    import shifter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_amt,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [2:0] sh_op,
    output logic [1:0] sh_shamt,
    output logic [7:0] sh_d_in,
    input  logic [7:0] sh_d_out
);

    state_t     r_state;
    logic [1:0] r_op;
    logic [3:0] r_rem;
    logic [7:0] r_data;
    logic [7:0] r_result;
    logic       r_done;
    logic [2:0] r_sh_op;
    logic [1:0] r_sh_shamt;

    logic [1:0] w_step;

    // r_rem is already reduced by the step being issued, so the decision
    // made in LOAD and in SHIFT is the same: another step, or capture.
    assign w_step = step_of(r_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_LSL;
            r_rem      <= 4'd0;
            r_data     <= 8'h00;
            r_result   <= 8'h00;
            r_done     <= 1'b0;
            r_sh_op    <= SH_NOP;
            r_sh_shamt <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sh_op    <= SH_NOP;
                    r_sh_shamt <= 2'd0;
                    if (start) begin
                        r_op    <= cmd_op;
                        r_rem   <= (cmd_op == OP_RSVD) ? 4'd0 : cmd_amt;
                        r_data  <= cmd_data;
                        r_sh_op <= SH_LOAD;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (r_rem != 4'd0) begin
                        r_sh_op    <= op_to_sh(r_op);
                        r_sh_shamt <= w_step;
                        r_rem      <= r_rem - {2'b00, w_step};
                        r_state    <= ST_SHIFT;
                    end else begin
                        // Shifter holds its value through CAPT.
                        r_sh_op    <= SH_NOP;
                        r_sh_shamt <= 2'd0;
                        r_state    <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    r_result   <= sh_d_out;
                    r_done     <= 1'b1;
                    r_sh_op    <= SH_NOP;
                    r_sh_shamt <= 2'd0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign sh_op    = r_sh_op;
    assign sh_shamt = r_sh_shamt;
    assign sh_d_in  = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cmd_op;
    logic [3:0] cmd_amt;
    logic [7:0] cmd_data;
    logic       busy, done;
    logic [7:0] result;
    logic [2:0] sh_op;
    logic [1:0] sh_shamt;
    logic [7:0] sh_d_in;
    logic [7:0] sh_d_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .cmd_data(cmd_data), .busy(busy), .done(done),
        .result(result), .sh_op(sh_op), .sh_shamt(sh_shamt),
        .sh_d_in(sh_d_in), .sh_d_out(sh_d_out)
    );

    // Behavioural shifter8: registered output, reset_n tied to ~reset.
    always @(posedge clk) begin
        if (reset) sh_d_out <= 8'h00;
        else case (sh_op)
            3'b001: sh_d_out <= sh_d_in;
            3'b010: sh_d_out <= sh_d_out << sh_shamt;
            3'b011: sh_d_out <= sh_d_out >> sh_shamt;
            3'b100: sh_d_out <= 8'($signed(sh_d_out) >>> sh_shamt);
            default: sh_d_out <= sh_d_out;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] amt;
        logic [7:0] data;
        logic [2:0] shop;   // shifter op expected during SHIFT
        logic [7:0] res;
        int         lat;    // edges from start edge to done cycle
        int         nsteps;
        bit         noise;  // pulse start with junk while busy
    } vec_t;

    vec_t vecs[9];

    // Starts at a negedge, returns at the negedge of the done cycle, so a
    // following call issues start in the done cycle (back-to-back).
    task automatic run_cmd(input vec_t v);
        int  k, rem, steps, st;
        bit  got;
        start = 1'b1; cmd_op = v.op; cmd_amt = v.amt; cmd_data = v.data;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_done_low", 32'(done), 32'd0);
        chk("load_shop", 32'(sh_op), 32'h1);
        chk("load_din", 32'(sh_d_in), 32'(v.data));
        rem   = (v.op == 2'b11) ? 0 : int'(v.amt);
        steps = 0;
        k     = 1;
        got   = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (done) begin
                got   = 1'b1;
                start = 1'b0;
            end else begin
                if (rem > 0) begin
                    st = (rem >= 3) ? 3 : rem;
                    chk("step_op", 32'(sh_op), 32'(v.shop));
                    chk("step_amt", 32'(sh_shamt), 32'(st));
                    rem -= st;
                    steps++;
                end else begin
                    chk("capt_nop", 32'(sh_op), 32'h0);
                end
                chk("mid_busy", 32'(busy), 32'd1);
                if (v.noise) begin
                    start = 1'b1; cmd_op = 2'b00; cmd_amt = 4'd1;
                    cmd_data = 8'($urandom);
                end
            end
        end
        chk("latency", 32'(k), 32'(v.lat));
        chk("result", 32'(result), 32'(v.res));
        chk("done_busy", 32'(busy), 32'd0);
        chk("nsteps", 32'(steps), 32'(v.nsteps));
        chk("done_nop", 32'(sh_op), 32'h0);
    endtask

    initial begin
        vec_t v1;
        reset = 1'b1; start = 1'b0; cmd_op = 2'b00; cmd_amt = 4'd0; cmd_data = 8'h00;

        //        op     amt    data   shop    res    lat ns noise
        vecs[0] = '{2'b00, 4'd5,  8'h03, 3'b010, 8'h60, 5, 2, 1'b0};
        vecs[1] = '{2'b10, 4'd7,  8'h80, 3'b100, 8'hFF, 6, 3, 1'b0};
        vecs[2] = '{2'b01, 4'd0,  8'hA5, 3'b011, 8'hA5, 3, 0, 1'b0};
        vecs[3] = '{2'b01, 4'd15, 8'hFF, 3'b011, 8'h00, 8, 5, 1'b1};
        vecs[4] = '{2'b11, 4'd9,  8'h3C, 3'b000, 8'h3C, 3, 0, 1'b0};
        vecs[5] = '{2'b00, 4'd1,  8'h01, 3'b010, 8'h02, 4, 1, 1'b0};
        vecs[6] = '{2'b10, 4'd4,  8'h70, 3'b100, 8'h07, 5, 2, 1'b0};
        vecs[7] = '{2'b00, 4'd13, 8'hFF, 3'b010, 8'h00, 8, 5, 1'b0};
        vecs[8] = '{2'b10, 4'd13, 8'h80, 3'b100, 8'hFF, 8, 5, 1'b1};

        // Reset for two cycles, then idle with start low.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_result", 32'(result), 32'h00);
            chk("rst_shop", 32'(sh_op), 32'h0);
            chk("rst_shamt", 32'(sh_shamt), 32'h0);
            chk("rst_din", 32'(sh_d_in), 32'h00);
        end

        // Back-to-back table run.
        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);
        @(negedge clk);
        chk("done_pulse_once", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'hFF);

        // Reset in the 2nd SHIFT cycle of LSL amt 9.
        start = 1'b1; cmd_op = 2'b00; cmd_amt = 4'd9; cmd_data = 8'h01;
        @(posedge clk); @(negedge clk);       // LOAD
        start = 1'b0;
        @(posedge clk); @(negedge clk);       // SHIFT 1
        chk("rm_shift1", 32'(sh_op), 32'h2);
        @(posedge clk); @(negedge clk);       // SHIFT 2
        chk("rm_shift2", 32'(sh_shamt), 32'd3);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_shop", 32'(sh_op), 32'h0);
        chk("rm_done", 32'(done), 32'd0);
        chk("rm_result", 32'(result), 32'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rm_no_done", 32'(done), 32'd0);
            chk("rm_idle", 32'(busy), 32'd0);
        end
        v1 = '{2'b00, 4'd1, 8'h01, 3'b010, 8'h02, 4, 1, 1'b0};
        run_cmd(v1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
